event_gen: RTL and testbench

EVENT_GEN -- requirements
Module: event_gen

---
 rtl/pdes_pkg.sv | 22 ++
 rtl/event_gen.sv | 127 ++++++++++++
 tb/tb_event_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pdes_pkg.sv
// pdes_pkg: shared definitions for the PDES event-generation slice.
//   TIME_W_DEF / LP_BITS_DEF : default timestamp and LP-index widths
//   state_t                  : event generator FSM states
//   ev_rec_t                 : generated event record (timestamp, target LP, saturation flag)
package pdes_pkg;

  localparam int unsigned TIME_W_DEF  = 32;
  localparam int unsigned LP_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    EMIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TIME_W_DEF-1:0]  ts;
    logic [LP_BITS_DEF-1:0] lp;
    logic                   sat;
  } ev_rec_t;

endpackage

// File: rtl/event_gen.sv
// event_gen: turns a core request into a future event using three random
// fields from an external LFSR (delay, target LP, timestamp offset).
//
// Parameters: NBITS (bits per random field), LP_BITS (target index width),
//             TIME_W (timestamp width).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   cur_time/cur_lp : requester timestamp and LP index
//   rnd             : {offset, target, delay} from the LFSR
//   next            : one-cycle LFSR advance pulse on the accept cycle
//   ev_valid/ready  : generated event handshake
//   ev_time/lp/sat  : generated event fields
//
// Build option: EVENT_GEN_SELF_SEND_EN -- when defined the target LP may equal
// the requester; when undefined a self-targeted event is bumped to cur_lp+1.
module event_gen
  import pdes_pkg::*;
#(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned LP_BITS = LP_BITS_DEF,
  parameter int unsigned TIME_W  = TIME_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TIME_W-1:0]    cur_time,
  input  logic [LP_BITS-1:0]   cur_lp,
  input  logic [3*NBITS-1:0]   rnd,
  output logic                 next,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [TIME_W-1:0]    ev_time,
  output logic [LP_BITS-1:0]   ev_lp,
  output logic                 ev_sat
);

  state_t               state_q;
  logic [NBITS-1:0]     cnt_q;
  logic                 ev_valid_q;
  logic [TIME_W-1:0]    ev_time_q;
  logic [LP_BITS-1:0]   ev_lp_q;
  logic                 ev_sat_q;

  logic [NBITS-1:0]     delay_f;
  logic [NBITS-1:0]     target_f;
  logic [NBITS-1:0]     offset_f;
  logic [TIME_W:0]      sum_w;
  logic [TIME_W-1:0]    ev_time_d;
  logic [LP_BITS-1:0]   ev_lp_d;
  logic                 ev_sat_d;
  logic                 accept;
  logic                 unused_target_hi;

  assign delay_f  = rnd[0+:NBITS];
  assign target_f = rnd[NBITS+:NBITS];
  assign offset_f = rnd[2*NBITS+:NBITS];

  // Upper target bits are dropped by the modulo-NUM_LP truncation.
  assign unused_target_hi = ^target_f;

  assign accept    = (state_q == IDLE) && req_valid && !rst;
  assign req_ready = (state_q == IDLE);
  assign next      = accept;

  // Event fields are computed from the inputs present on the accept cycle and
  // registered at the accept edge, so later input changes cannot leak in.
  always_comb begin
    sum_w     = {1'b0, cur_time} + (TIME_W+1)'(offset_f) + (TIME_W+1)'(1);
    ev_sat_d  = sum_w[TIME_W];
    ev_time_d = ev_sat_d ? '1 : sum_w[TIME_W-1:0];
    ev_lp_d   = target_f[LP_BITS-1:0];
`ifndef EVENT_GEN_SELF_SEND_EN
    if (ev_lp_d == cur_lp) begin
      ev_lp_d = cur_lp + LP_BITS'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_time_q  <= '0;
      ev_lp_q    <= '0;
      ev_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cnt_q     <= delay_f;
            ev_time_q <= ev_time_d;
            ev_lp_q   <= ev_lp_d;
            ev_sat_q  <= ev_sat_d;
            state_q   <= DELAY;
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            ev_valid_q <= 1'b1;
            state_q    <= EMIT;
          end else begin
            cnt_q <= cnt_q - NBITS'(1);
          end
        end
        EMIT: begin
          if (ev_ready) begin
            ev_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          ev_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_time  = ev_time_q;
  assign ev_lp    = ev_lp_q;
  assign ev_sat   = ev_sat_q;

endmodule

// File: tb/tb_event_gen.sv
// tb_event_gen: directed scoreboard bench for event_gen (NBITS=8, LP_BITS=4,
// TIME_W=32). Expected events are pushed when a request is driven and popped
// when the DUT presents ev_valid.
module tb_event_gen;
  import pdes_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] cur_time;
  logic [3:0]  cur_lp;
  logic [23:0] rnd;
  logic        next;
  logic        ev_valid;
  logic        ev_ready;
  logic [31:0] ev_time;
  logic [3:0]  ev_lp;
  logic        ev_sat;

  int checks = 0;
  int errors = 0;

  ev_rec_t sb_q[$];
  int      dly_q[$];

  event_gen #(.NBITS(8), .LP_BITS(4), .TIME_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .cur_time(cur_time), .cur_lp(cur_lp), .rnd(rnd), .next(next),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_time(ev_time), .ev_lp(ev_lp), .ev_sat(ev_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_rec_t model(input logic [31:0] t, input logic [3:0] lp,
                                    input logic [7:0] tg, input logic [7:0] of);
    ev_rec_t     r;
    logic [32:0] s;
    s = {1'b0, t} + {25'd0, of} + 33'd1;
    r.sat = s[32];
    r.ts  = s[32] ? 32'hFFFF_FFFF : s[31:0];
    r.lp  = tg[3:0];
`ifndef EVENT_GEN_SELF_SEND_EN
    if (r.lp == lp) r.lp = lp + 4'd1;
`endif
    return r;
  endfunction

  // Drive one request; the accept edge is the next posedge. Returns #1 after it.
  task automatic send(input logic [31:0] t, input logic [3:0] lp,
                      input logic [7:0] d, input logic [7:0] tg, input logic [7:0] of);
    @(negedge clk);
    req_valid = 1'b1;
    cur_time  = t;
    cur_lp    = lp;
    rnd       = {of, tg, d};
    sb_q.push_back(model(t, lp, tg, of));
    dly_q.push_back(int'(d));
    #1;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    chk("next_at_accept", {63'd0, next}, 64'd1);
    @(posedge clk);
    #1;
    // Busy: keep requesting and scramble inputs; none of it may matter.
    cur_time = ~t;
    cur_lp   = ~lp;
    rnd      = ~{of, tg, d};
    #1;
    chk("next_after_accept", {63'd0, next}, 64'd0);
    chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
  endtask

  // Wait for ev_valid, check latency and fields, hold ev_ready low, then handshake.
  task automatic receive(input int hold);
    int      n;
    int      d;
    ev_rec_t e;
    ev_rec_t z;
    n = 0;
    while (!ev_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() == 0 || dly_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    d = dly_q.pop_front();
    chk("ev_valid_latency", 64'(n), 64'(d + 1));
    chk("ev_time", {32'd0, ev_time}, {32'd0, e.ts});
    chk("ev_lp", {60'd0, ev_lp}, {60'd0, e.lp});
    chk("ev_sat", {63'd0, ev_sat}, {63'd0, e.sat});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      z.ts = ev_time; z.lp = ev_lp; z.sat = ev_sat;
      chk("hold_valid", {63'd0, ev_valid}, 64'd1);
      chk("hold_fields", {23'd0, z}, {23'd0, e});
      chk("hold_ready", {62'd0, req_ready, next}, 64'd0);
    end
    // Handshake cycle with a competing request: must not be accepted.
    ev_ready = 1'b1;
    #1;
    chk("next_in_handshake", {63'd0, next}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ev_ready  = 1'b0;
    chk("ev_valid_after_hs", {63'd0, ev_valid}, 64'd0);
    chk("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; ev_ready = 1'b0;
    cur_time = '0; cur_lp = '0; rnd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_outputs", {26'd0, ev_valid, ev_sat, ev_lp, ev_time, next}, 64'd0);
    rst = 1'b0;

    send(32'd100, 4'd1, 8'h03, 8'h23, 8'h05);          // lp 3, t 106
    receive(0);
    send(32'd7, 4'd2, 8'h00, 8'h00, 8'h00);            // delay 0, t 8
    receive(0);
    send(32'd50, 4'd5, 8'h02, 8'h47, 8'h09);           // held 5 cycles
    receive(5);
    send(32'hFFFF_FFFE, 4'd0, 8'h01, 8'h01, 8'h10);    // saturates
    receive(1);
    send(32'hFFFF_FFFE, 4'd0, 8'h01, 8'h02, 8'h00);    // exactly all ones, no sat
    receive(0);
    send(32'hFFFF_FFFF, 4'd0, 8'h00, 8'h02, 8'h00);    // +1 overflows
    receive(0);
    send(32'd1000, 4'd3, 8'h04, 8'h13, 8'h20);         // self target
    receive(0);
    send(32'd2000, 4'd15, 8'h01, 8'h0F, 8'hFF);        // self target wraps
    receive(2);
    send(32'd3, 4'd9, 8'hFF, 8'hA6, 8'h80);            // max delay
    receive(0);

    // Reset in the middle of DELAY discards the pending event.
    send(32'd500, 4'd4, 8'd10, 8'h07, 8'h01);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    req_valid = 1'b1;
    ev_ready = 1'b1;
    #1;
    chk("next_under_rst", {63'd0, next}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; ev_ready = 1'b0;
    chk("midrst_ev_valid", {63'd0, ev_valid}, 64'd0);
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_fields", {27'd0, ev_sat, ev_lp, ev_time}, 64'd0);
    void'(sb_q.pop_back());
    void'(dly_q.pop_back());
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ev_valid) seen++;
    end
    chk("no_event_after_rst", 64'(seen), 64'd0);

    send(32'd42, 4'd0, 8'h01, 8'h05, 8'h03);           // recovers after reset
    receive(0);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
